map_read_arbiter: RTL
=====================

Name: map_read_arbiter

Overview:
- Shares the single read port of the 64x80 pacman map block memory among several requesters: the video tile fetcher, the pacman movement/collision checker and the ghost AI.
- Requester 0 (video) has fixed priority. Requesters 1..NUM_REQ-1 share the remaining slots round-robin. A starvation counter guarantees progress for the low-priority requesters.
- Sits between the game/render logic and the map memory. It drives the memory address and returns each read row, tagged, to the requester that issued it.

Parameters:
- NUM_REQ, 3, number of requesters (>=2); index 0 is the priority (video) port.
- RD_LAT, 1, memory read latency in cycles from address register to valid douta (legal 1..3).
- MAP_ROWS, 60, number of valid map rows; addresses >= MAP_ROWS read as wall.
- STARVE_MAX, 8, low-priority wait cycles tolerated before overriding requester 0.

Ports:
- clka  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester read request, held until granted.
- req_addr  in  NUM_REQ*6  packed row addresses; requester i uses bits [6i+5:6i].
- gnt  out  NUM_REQ  one-hot grant, combinational, at most one bit high.
- rvalid  out  NUM_REQ  one-hot, one-cycle pulse: rdata belongs to requester i.
- rdata  out  80  returned map row.
- rom_addra  out  6  registered address to map memory.
- rom_douta  in  80  data from map memory.

Behaviour:
- Reset (async, rst_n=0):
  - rom_addra=0, rvalid=0, gnt forced 0.
  - rr_ptr=1, wait_cnt=0.
  - In-flight pipeline tags cleared.
- Handshake:
  - Requester raises req[i] with req_addr stable.
  - gnt[i] is high in the cycle the request is accepted; the requester may drop or change req/addr from the next cycle.
  - Holding req[i] high after a grant is a new request.
- Issue, cycle T (gnt[i] high):
  - At the edge ending T: rom_addra <= addr_i, and tag {valid, id=i, oob=(addr_i>=MAP_ROWS)} enters a delay line of depth 1+RD_LAT.
- Return:
  - rvalid[i]=1 exactly in cycle T+1+RD_LAT.
  - rdata = rom_douta, or 80'hFFFF_FFFF_FFFF_FFFF_FFFF when oob.
  - rdata is don't-care when no rvalid bit is set.
- Throughput: one grant per cycle, fully pipelined, no bubbles between back-to-back grants.
- Arbitration each cycle:
  - Candidate L = first i with req[i]=1, searching rr_ptr, rr_ptr+1, ..., NUM_REQ-1, then 1, ..., rr_ptr-1.
  - If wait_cnt >= STARVE_MAX and L exists: grant L.
  - Else if req[0]: grant 0.
  - Else if L exists: grant L.
  - Else: no grant.
- rr_ptr update: after granting L, rr_ptr <= L+1, wrapping to 1 past NUM_REQ-1. It is unchanged on a grant to 0 or no grant.
- wait_cnt:
  - Cleared on any grant to a low-priority requester.
  - Otherwise incremented when any req[1..NUM_REQ-1] is high.
  - Otherwise cleared.
  - Saturates at STARVE_MAX.
- rom_addra holds its last value when no grant.
- Reset mid-operation: all pending tags dropped; no rvalid for pre-reset grants after release. The first grant after release follows normal timing.
- Simultaneous return and new grant are independent (pipeline); no conflict.

Test Plan:
1. RD_LAT=1. req[1]=1, addr=5 in cycle 10 only -> gnt[1] in cycle 10; rom_addra=5 from cycle 11; rvalid=3'b010 in cycle 12 with rdata=row 5; no other rvalid.
2. req[0] and req[1] held continuously, STARVE_MAX=8 -> gnt[0] for 8 cycles, then gnt[1] on cycle 9; pattern then repeats (8 video grants, 1 low grant).
3. req[0]=0, req[1] and req[2] held -> grants alternate 1,2,1,2; rvalid order matches grant order.
4. req[2]=1, addr=62, MAP_ROWS=60 -> gnt[2]; two cycles later rvalid[2] with rdata all ones.
5. req[0] presents addrs 0,1,2,3 in consecutive cycles -> four consecutive rvalid[0] pulses carrying rows 0,1,2,3 in order, with no gaps.
6. Grant issued, then rst_n=0 for 1 cycle before its return -> no rvalid ever appears for that grant; rom_addra=0; rr_ptr=1.

Source files
------------

// File: rtl/map_read_arbiter.sv
// Read-port arbiter for the 64x80 pacman map memory.
// Video has fixed priority; other ports share round-robin with a starvation override.
module map_read_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int RD_LAT     = 1,
    parameter int MAP_ROWS   = 60,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clka,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*6-1:0]   req_addr,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rvalid,
    output logic [79:0]            rdata,
    output logic [5:0]             rom_addra,
    input  logic [79:0]            rom_douta
);

    localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int WW  = $clog2(STARVE_MAX + 1);

    localparam logic [IDW-1:0] FIRST_LOW = IDW'(1);
    localparam logic [IDW-1:0] LAST_LOW  = IDW'(NUM_REQ - 1);
    localparam logic [WW-1:0]  WAIT_SAT  = WW'(STARVE_MAX);
    localparam logic [WW-1:0]  WAIT_ONE  = WW'(1);
    localparam logic [6:0]     ROWS_LIM  = 7'(MAP_ROWS);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           oob;
    } tag_t;

    logic [5:0]     rom_addra_q, rom_addra_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]  wait_q, wait_d;
    tag_t           tag_q [RD_LAT+1];
    tag_t           tag_d [RD_LAT+1];

    logic           hi_found, lo_found, cand_found;
    logic [IDW-1:0] hi_id, lo_id, cand_id;
    logic [NUM_REQ-1:0] grant_raw;
    logic           grant_low;
    logic [IDW-1:0] grant_id;
    logic [5:0]     addr_sel;
    logic           low_req;

    // Round-robin candidate: first requester at/after rr_ptr, else first below it
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = FIRST_LOW;
        lo_id    = FIRST_LOW;
        for (int i = NUM_REQ - 1; i >= 1; i--) begin
            if (req[i] && (IDW'(i) >= rr_ptr_q)) begin
                hi_found = 1'b1;
                hi_id    = IDW'(i);
            end
            if (req[i] && (IDW'(i) < rr_ptr_q)) begin
                lo_found = 1'b1;
                lo_id    = IDW'(i);
            end
        end
        cand_found = hi_found | lo_found;
        cand_id    = hi_found ? hi_id : lo_id;
    end

    // Grant selection: starved low port, then video, then low port
    always_comb begin
        grant_raw = '0;
        grant_low = 1'b0;
        grant_id  = '0;
        if (cand_found && (wait_q >= WAIT_SAT)) begin
            grant_raw[cand_id] = 1'b1;
            grant_low          = 1'b1;
            grant_id           = cand_id;
        end else if (req[0]) begin
            grant_raw[0] = 1'b1;
        end else if (cand_found) begin
            grant_raw[cand_id] = 1'b1;
            grant_low          = 1'b1;
            grant_id           = cand_id;
        end
        addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_raw[i]) begin
                addr_sel = req_addr[i*6 +: 6];
            end
        end
        gnt = rst_n ? grant_raw : '0;
    end

    // Next-state for address, pointer, starvation counter and tag pipeline
    always_comb begin
        low_req     = |req[NUM_REQ-1:1];
        rom_addra_d = (|grant_raw) ? addr_sel : rom_addra_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_low) begin
            rr_ptr_d = (cand_id == LAST_LOW) ? FIRST_LOW : cand_id + FIRST_LOW;
        end
        if (grant_low) begin
            wait_d = '0;
        end else if (low_req) begin
            wait_d = (wait_q >= WAIT_SAT) ? WAIT_SAT : wait_q + WAIT_ONE;
        end else begin
            wait_d = '0;
        end
        tag_d[0].valid = |grant_raw;
        tag_d[0].id    = grant_id;
        tag_d[0].oob   = ({1'b0, addr_sel} >= ROWS_LIM);
        for (int k = 1; k <= RD_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // State registers; reset drops every in-flight tag
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            rom_addra_q <= '0;
            rr_ptr_q    <= FIRST_LOW;
            wait_q      <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            rom_addra_q <= rom_addra_d;
            rr_ptr_q    <= rr_ptr_d;
            wait_q      <= wait_d;
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    // Return path: tag at the end of the line lines up with douta
    always_comb begin
        rom_addra = rom_addra_q;
        rvalid    = '0;
        if (tag_q[RD_LAT].valid) begin
            rvalid[tag_q[RD_LAT].id] = 1'b1;
        end
        rdata = tag_q[RD_LAT].oob ? '1 : rom_douta;
    end

endmodule
